// File: rtl/vec_norm_if.sv
// vec_norm_if -- handshake bundle for the vec_norm Euclidean-length engine.
//
// Parameters
//   WIDTH  component width (signed Q<WIDTH>.0)
//   DIM    number of vector components
//
// Signals
//   sink_valid    producer -> engine   sink_vec holds a valid vector
//   sink_ready    engine   -> producer engine accepts a vector this cycle
//   sink_vec      producer -> engine   packed components, component i at [i*WIDTH +: WIDTH]
//   source_valid  engine   -> consumer source holds a valid result
//   source_ready  consumer -> engine   consumer takes the result this cycle
//   source        engine   -> consumer unsigned Euclidean length, OWIDTH bits
//
// Modports
//   master  drives the vector side and accepts results (testbench / upstream)
//   slave   the vec_norm engine itself
interface vec_norm_if #(
  parameter int WIDTH = 16,
  parameter int DIM   = 3
);

  // The sum of DIM squares needs 2*WIDTH-1 bits per term plus growth for the
  // additions; rounding that up to even lets the root be exactly half as wide.
  localparam int SWIDTH = 2 * WIDTH - 1 + $clog2(DIM);
  localparam int SW     = SWIDTH + (SWIDTH % 2);
  localparam int OWIDTH = SW / 2;

  logic                   sink_valid;
  logic                   sink_ready;
  logic [DIM*WIDTH-1:0]   sink_vec;
  logic                   source_valid;
  logic                   source_ready;
  logic [OWIDTH-1:0]      source;

  modport master (
    output sink_valid,
    output sink_vec,
    output source_ready,
    input  sink_ready,
    input  source_valid,
    input  source
  );

  modport slave (
    input  sink_valid,
    input  sink_vec,
    input  source_ready,
    output sink_ready,
    output source_valid,
    output source
  );

endinterface

// File: rtl/vec_norm.sv
// vec_norm -- sequential Euclidean length of a signed integer vector.
//
// Accepts one vector of DIM signed components, accumulates the sum of squares
// one component per cycle, then extracts the integer square root one bit per
// cycle (restoring, MSB first). The result is either floor(sqrt(S)) or, with
// ROUND=1, sqrt rounded to nearest. Latency from acceptance to source_valid is
// a fixed DIM+OWIDTH cycles regardless of the data.
//
// Parameters
//   WIDTH  component width, signed Q<WIDTH>.0, WIDTH >= 2
//   DIM    number of components, DIM >= 1
//   ROUND  0 = floor of the root, 1 = root rounded to nearest integer
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   io     vec_norm_if.slave: sink_valid/sink_ready/sink_vec in,
//          source_valid/source_ready/source out (OWIDTH bits)
module vec_norm #(
  parameter int WIDTH = 16,
  parameter int DIM   = 3,
  parameter int ROUND = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  vec_norm_if.slave   io
);

  localparam int SWIDTH = 2 * WIDTH - 1 + $clog2(DIM);
  localparam int SW     = SWIDTH + (SWIDTH % 2);
  localparam int OWIDTH = SW / 2;
  // The partial remainder never exceeds twice the partial root, so two extra
  // bits over the root width are enough to hold it between steps.
  localparam int RW     = OWIDTH + 2;
  // One counter walks the components in SQUARE and the root bits in ROOT.
  localparam int CMAX   = (DIM > OWIDTH) ? DIM : OWIDTH;
  localparam int CNTW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

  state_t                state;
  logic                  sink_ready_q;
  logic                  source_valid_q;
  logic [OWIDTH-1:0]     source_q;
  logic [DIM*WIDTH-1:0]  vec_q;
  logic [SW-1:0]         acc;
  logic [RW-1:0]         rem;
  logic [OWIDTH-1:0]     root;
  logic [CNTW-1:0]       cnt;

  logic signed [2*WIDTH-1:0] comp_ext;
  logic [2*WIDTH-1:0]        sq;
  logic [RW+1:0]             rem_shift;
  logic [RW+1:0]             trial;
  logic [RW-1:0]             rem_next;
  logic [OWIDTH-1:0]         root_next;
  logic                      round_up;
  logic [OWIDTH-1:0]         result;
  logic                      last_comp;
  logic                      last_bit;

  // Square of the current component. The latched vector is shifted down one
  // component per SQUARE cycle, so the current one always sits in the low bits.
  // Sign-extending to 2*WIDTH first keeps (-2^(WIDTH-1))^2 exact.
  always_comb begin
    comp_ext = {{WIDTH{vec_q[WIDTH-1]}}, vec_q[WIDTH-1:0]};
    sq       = comp_ext * comp_ext;
  end

  // One restoring square-root step: bring down the next two radicand bits
  // (top of the accumulator, which shifts left by two each step) and try to
  // subtract 4*root+1. The subtraction result always fits back into RW bits.
  always_comb begin
    rem_shift = {rem, acc[SW-1 -: 2]};
    trial     = {2'b00, root, 2'b01};
    if (rem_shift >= trial) begin
      rem_next  = RW'(rem_shift - trial);
      root_next = {root[OWIDTH-2:0], 1'b1};
    end else begin
      rem_next  = RW'(rem_shift);
      root_next = {root[OWIDTH-2:0], 1'b0};
    end
  end

  // After the final step rem_next = S - r^2; the root rounds up exactly when
  // that remainder exceeds r, i.e. when S > (r + 0.5)^2.
  always_comb begin
    round_up = rem_next > {2'b00, root_next};
    result   = root_next;
    if (ROUND != 0 && round_up) begin
      result = root_next + OWIDTH'(1);
    end
  end

  always_comb begin
    last_comp = (cnt == CNTW'(DIM - 1));
    last_bit  = (cnt == CNTW'(OWIDTH - 1));
  end

  // Control and datapath state. sink_ready and source_valid are registered so
  // they drop with reset and sink_ready rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sink_ready_q   <= 1'b0;
      source_valid_q <= 1'b0;
      source_q       <= '0;
      vec_q          <= '0;
      acc            <= '0;
      rem            <= '0;
      root           <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sink_ready_q && io.sink_valid) begin
            vec_q        <= io.sink_vec;
            acc          <= '0;
            rem          <= '0;
            root         <= '0;
            cnt          <= '0;
            sink_ready_q <= 1'b0;
            state        <= SQUARE;
          end else begin
            sink_ready_q <= 1'b1;
          end
        end

        SQUARE: begin
          acc   <= acc + SW'(sq);
          vec_q <= vec_q >> WIDTH;
          if (last_comp) begin
            cnt   <= '0;
            state <= ROOT;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end

        ROOT: begin
          acc  <= acc << 2;
          rem  <= rem_next;
          root <= root_next;
          if (last_bit) begin
            cnt            <= '0;
            source_q       <= result;
            source_valid_q <= 1'b1;
            state          <= DONE;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end

        DONE: begin
          // source_q is left alone so the last result stays visible until the
          // next vector completes.
          if (io.source_ready) begin
            source_valid_q <= 1'b0;
            sink_ready_q   <= 1'b1;
            state          <= IDLE;
          end
        end

        default: begin
          state          <= IDLE;
          sink_ready_q   <= 1'b0;
          source_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.sink_ready   = sink_ready_q;
  assign io.source_valid = source_valid_q;
  assign io.source       = source_q;

endmodule

// File: tb/tb_vec_norm.sv
// tb_vec_norm -- self-checking bench for vec_norm.
//
// Three engines share clock and reset:
//   dut_a  WIDTH=8 DIM=3 ROUND=0 (OWIDTH=9)
//   dut_b  WIDTH=8 DIM=3 ROUND=1, driven in lockstep with dut_a
//   dut_c  WIDTH=8 DIM=1 ROUND=0 (OWIDTH=8)
// Expected values come from constant tables and from a reference model that
// computes the Euclidean length with plain integer arithmetic.
module tb_vec_norm;

  localparam int OW3  = 9;
  localparam int OW1  = 8;
  localparam int LAT3 = 3 + OW3;
  localparam int LAT1 = 1 + OW1;

  typedef struct {
    int c0;
    int c1;
    int c2;
    int exp_floor;
    int exp_round;
  } vec3_t;

  typedef struct {
    int c0;
    int exp_floor;
  } vec1_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vec_norm_if #(.WIDTH(8), .DIM(3)) if_a ();
  vec_norm_if #(.WIDTH(8), .DIM(3)) if_b ();
  vec_norm_if #(.WIDTH(8), .DIM(1)) if_c ();

  vec_norm #(.WIDTH(8), .DIM(3), .ROUND(0)) dut_a (.clk(clk), .rst_n(rst_n), .io(if_a));
  vec_norm #(.WIDTH(8), .DIM(3), .ROUND(1)) dut_b (.clk(clk), .rst_n(rst_n), .io(if_b));
  vec_norm #(.WIDTH(8), .DIM(1), .ROUND(0)) dut_c (.clk(clk), .rst_n(rst_n), .io(if_c));

  assign if_b.sink_valid   = if_a.sink_valid;
  assign if_b.sink_vec     = if_a.sink_vec;
  assign if_b.source_ready = if_a.source_ready;

  // Reference model: integer square root by search around the real root.
  function automatic longint isqrt(input longint s);
    longint r;
    r = longint'($sqrt(real'(s)));
    while ((r + 1) * (r + 1) <= s) r++;
    while (r * r > s) r--;
    return r;
  endfunction

  function automatic longint norm_ref(input longint s, input bit rnd);
    longint r;
    r = isqrt(s);
    if (rnd && (s - r * r > r)) r++;
    return r;
  endfunction

  function automatic longint sum_sq(input logic [23:0] v, input int dim);
    longint s;
    longint c;
    s = 0;
    for (int i = 0; i < dim; i++) begin
      c = longint'($signed(v[i*8 +: 8]));
      s += c * c;
    end
    return s;
  endfunction

  function automatic logic [23:0] pack3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int rand_comp();
    case ($urandom_range(0, 3))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Offer a vector to dut_a/dut_b, then keep sink_valid high with junk data
  // while the engines are busy (it must be ignored) until the result appears.
  task automatic apply_stimulus3(input logic [23:0] v, output int lat);
    int guard;
    bit busy_ready;
    @(negedge clk);
    if_a.sink_vec   = v;
    if_a.sink_valid = 1'b1;
    guard = 0;
    while (!if_a.sink_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 if_a.sink_vec = 24'($urandom);
    lat = 0;
    busy_ready = 1'b0;
    while (!if_a.source_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (if_a.sink_ready) busy_ready = 1'b1;
    end
    if_a.sink_valid = 1'b0;
    check_output("busy_sink_ready", busy_ready, 0);
    check_output("lockstep_valid_b", if_b.source_valid, 1);
  endtask

  task automatic release3();
    @(negedge clk);
    if_a.source_ready = 1'b1;
    @(posedge clk);
    #1 if_a.source_ready = 1'b0;
    check_output("release_valid", if_a.source_valid, 0);
    check_output("release_ready", if_a.sink_ready, 1);
  endtask

  task automatic run3(input logic [23:0] v, output int lat,
                      output logic [8:0] res_a, output logic [8:0] res_b);
    apply_stimulus3(v, lat);
    res_a = if_a.source;
    res_b = if_b.source;
    release3();
  endtask

  task automatic run1(input int c0, output int lat, output logic [7:0] res);
    int guard;
    @(negedge clk);
    if_c.sink_vec   = 8'(c0);
    if_c.sink_valid = 1'b1;
    guard = 0;
    while (!if_c.sink_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    if_c.sink_valid = 1'b0;
    if_c.sink_vec   = 8'($urandom);
    lat = 0;
    while (!if_c.source_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = if_c.source;
    @(negedge clk);
    if_c.source_ready = 1'b1;
    @(posedge clk);
    #1 if_c.source_ready = 1'b0;
    check_output("c_release_ready", if_c.sink_ready, 1);
  endtask

  // Continuous offering with source_ready high: results must come out in
  // order and between acceptances sink_ready stays low for the busy span of
  // SQUARE, ROOT and DONE (DIM+OWIDTH+1 cycles).
  task automatic back_to_back();
    longint qa[$];
    longint qb[$];
    int accepts;
    int outs;
    int busy;
    bit newvec;
    logic [23:0] v;
    accepts = 0;
    outs    = 0;
    busy    = 0;
    @(negedge clk);
    v = 24'($urandom);
    if_a.source_ready = 1'b1;
    if_a.sink_vec     = v;
    if_a.sink_valid   = 1'b1;
    for (int cyc = 0; cyc < 75; cyc++) begin
      newvec = 1'b0;
      if (if_a.source_valid) begin
        check_output("b2b_pending", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          check_output("b2b_res_a", if_a.source, qa.pop_front());
          check_output("b2b_res_b", if_b.source, qb.pop_front());
        end
        outs++;
      end
      if (if_a.sink_ready) begin
        if (accepts > 0) check_output("b2b_busy_span", busy, LAT3 + 1);
        qa.push_back(norm_ref(sum_sq(v, 3), 1'b0));
        qb.push_back(norm_ref(sum_sq(v, 3), 1'b1));
        accepts++;
        busy   = 0;
        newvec = 1'b1;
      end else begin
        busy++;
      end
      @(posedge clk);
      #1;
      if (newvec) begin
        v = 24'($urandom);
        if_a.sink_vec = v;
      end
      @(negedge clk);
    end
    if_a.sink_valid = 1'b0;
    for (int k = 0; k < 40 && qa.size() > 0; k++) begin
      if (if_a.source_valid) begin
        check_output("b2b_res_a", if_a.source, qa.pop_front());
        check_output("b2b_res_b", if_b.source, qb.pop_front());
        outs++;
      end
      @(negedge clk);
    end
    if_a.source_ready = 1'b0;
    check_output("b2b_drained", qa.size(), 0);
    check_output("b2b_accepts", accepts, (75 + LAT3 + 1) / (LAT3 + 2));
    check_output("b2b_outputs", outs, accepts);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec3_t       tab3[12];
    vec1_t       tab1[5];
    int          lat;
    logic [8:0]  ra;
    logic [8:0]  rb;
    logic [7:0]  rc;
    logic [23:0] v;
    longint      s;
    bit          seen;

    tab3[0]  = '{3, 4, 12, 13, 13};
    tab3[1]  = '{-128, -128, -128, 221, 222};
    tab3[2]  = '{0, 0, 0, 0, 0};
    tab3[3]  = '{1, 1, 1, 1, 2};
    tab3[4]  = '{127, 127, 127, 219, 220};
    tab3[5]  = '{1, 1, 0, 1, 1};
    tab3[6]  = '{-5, 0, 12, 13, 13};
    tab3[7]  = '{3, 3, 3, 5, 5};
    tab3[8]  = '{6, 6, 6, 10, 10};
    tab3[9]  = '{-1, 2, -2, 3, 3};
    tab3[10] = '{127, -128, 0, 180, 180};
    tab3[11] = '{0, 0, -128, 128, 128};

    tab1[0] = '{-128, 128};
    tab1[1] = '{0, 0};
    tab1[2] = '{127, 127};
    tab1[3] = '{-1, 1};
    tab1[4] = '{-77, 77};

    if_a.sink_valid   = 1'b0;
    if_a.sink_vec     = '0;
    if_a.source_ready = 1'b0;
    if_c.sink_valid   = 1'b0;
    if_c.sink_vec     = '0;
    if_c.source_ready = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check_output("rst_sink_ready_a", if_a.sink_ready, 0);
    check_output("rst_valid_a", if_a.source_valid, 0);
    check_output("rst_source_a", if_a.source, 0);
    check_output("rst_source_b", if_b.source, 0);
    check_output("rst_sink_ready_c", if_c.sink_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_ready_a", if_a.sink_ready, 1);
    check_output("post_rst_ready_c", if_c.sink_ready, 1);

    // Directed table, DIM=3, both rounding modes
    for (int i = 0; i < 12; i++) begin
      run3(pack3(tab3[i].c0, tab3[i].c1, tab3[i].c2), lat, ra, rb);
      check_output($sformatf("tab3_%0d_lat", i), lat, LAT3);
      check_output($sformatf("tab3_%0d_floor", i), ra, tab3[i].exp_floor);
      check_output($sformatf("tab3_%0d_round", i), rb, tab3[i].exp_round);
    end

    // Directed table, DIM=1
    for (int i = 0; i < 5; i++) begin
      run1(tab1[i].c0, lat, rc);
      check_output($sformatf("tab1_%0d_lat", i), lat, LAT1);
      check_output($sformatf("tab1_%0d_res", i), rc, tab1[i].exp_floor);
    end

    // Backpressure: result held in DONE for 5 cycles, then released
    apply_stimulus3(pack3(-5, 0, 12), lat);
    check_output("bp_lat", lat, LAT3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("bp_source", if_a.source, 13);
      check_output("bp_valid", if_a.source_valid, 1);
      check_output("bp_sink_ready", if_a.sink_ready, 0);
    end
    release3();
    repeat (3) begin
      @(negedge clk);
      check_output("bp_source_kept", if_a.source, 13);
    end

    // Reset in the middle of ROOT aborts the vector
    @(negedge clk);
    if_a.sink_vec   = pack3(3, 4, 12);
    if_a.sink_valid = 1'b1;
    @(posedge clk);
    #1 if_a.sink_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_valid_a", if_a.source_valid, 0);
    check_output("abort_source_a", if_a.source, 0);
    check_output("abort_source_b", if_b.source, 0);
    check_output("abort_sink_ready", if_a.sink_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (if_a.source_valid || if_b.source_valid) seen = 1'b1;
    end
    check_output("abort_no_result", seen, 0);
    check_output("abort_idle_ready", if_a.sink_ready, 1);
    run3(pack3(3, 4, 0), lat, ra, rb);
    check_output("abort_next_lat", lat, LAT3);
    check_output("abort_next_a", ra, 5);
    check_output("abort_next_b", rb, 5);

    // Randomized vectors against the reference model
    for (int i = 0; i < 24; i++) begin
      v = pack3(rand_comp(), rand_comp(), rand_comp());
      s = sum_sq(v, 3);
      run3(v, lat, ra, rb);
      check_output($sformatf("rand3_%0d_lat", i), lat, LAT3);
      check_output($sformatf("rand3_%0d_floor", i), ra, norm_ref(s, 1'b0));
      check_output($sformatf("rand3_%0d_round", i), rb, norm_ref(s, 1'b1));
    end
    for (int i = 0; i < 8; i++) begin
      int c;
      c = rand_comp();
      run1(c, lat, rc);
      check_output($sformatf("rand1_%0d_lat", i), lat, LAT1);
      check_output($sformatf("rand1_%0d_res", i), rc, norm_ref(longint'(c) * longint'(c), 1'b0));
    end

    // Back-to-back throughput with results in order
    back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
